// File: rtl/row_pkg.sv
`default_nettype none
// ============================================================================
// row_pkg : shared FSM state type and saturating / decay arithmetic helpers
// Rev 1.0
// ============================================================================
package row_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DECAY = 2'd2,
        ST_STDP  = 2'd3
    } state_e;

    // Unsigned add clamped to 2^width-1; callers size-cast the result to width.
    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                            input int width);
        logic [32:0] sum;
        logic [32:0] max;
        sum = {1'b0, a} + {1'b0, b};
        max = (33'd1 << width) - 33'd1;
        return (sum > max) ? max[31:0] : sum[31:0];
    endfunction

    function automatic logic [31:0] decay(input logic [31:0] x, input int shift);
        if (x < (32'd1 << shift))
            return 32'd0;
        return x - (x >> shift);
    endfunction

endpackage
`default_nettype wire

// File: rtl/synapse_row_tm_if.sv
`default_nettype none
// ============================================================================
// synapse_row_tm_if : row spike request handshake (valid/ready + slot address)
// Rev 1.0
// ============================================================================
interface synapse_row_tm_if #(
    parameter int SYN_PER_COL = 2
);
    localparam int SA_W = (SYN_PER_COL > 1) ? $clog2(SYN_PER_COL) : 1;

    logic            spike_valid;
    logic [SA_W-1:0] spike_addr;
    logic            spike_ready;

    modport master (output spike_valid, output spike_addr, input spike_ready);
    modport slave  (input spike_valid, input spike_addr, output spike_ready);
endinterface
`default_nettype wire

// File: rtl/row_weight_mem.sv
`default_nettype none
// ============================================================================
// row_weight_mem : NUM_COLS x SYN_PER_COL weight registers, one FSM read port,
//                  one FSM write port and a config write port that wins ties
// Rev 1.0
// ============================================================================
module row_weight_mem #(
    parameter int NUM_COLS    = 4,
    parameter int SYN_PER_COL = 2,
    parameter int W_WIDTH     = 8,
    parameter int CW          = 2,
    parameter int SW          = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [CW-1:0]      rd_col_i,
    input  logic [SW-1:0]      rd_syn_i,
    output logic [W_WIDTH-1:0] rd_data_o,
    input  logic               wr_en_i,
    input  logic [CW-1:0]      wr_col_i,
    input  logic [SW-1:0]      wr_syn_i,
    input  logic [W_WIDTH-1:0] wr_data_i,
    input  logic               cfg_we_i,
    input  logic [CW-1:0]      cfg_col_i,
    input  logic [SW-1:0]      cfg_syn_i,
    input  logic [W_WIDTH-1:0] cfg_wdata_i
);

    logic [W_WIDTH-1:0] w_q [NUM_COLS][SYN_PER_COL];

    // Matching by loop means out-of-range addresses simply hit nothing.
    always_comb begin
        rd_data_o = '0;
        for (int c = 0; c < NUM_COLS; c++)
            for (int s = 0; s < SYN_PER_COL; s++)
                if (rd_col_i == CW'(c) && rd_syn_i == SW'(s))
                    rd_data_o = w_q[c][s];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < NUM_COLS; c++)
                for (int s = 0; s < SYN_PER_COL; s++)
                    w_q[c][s] <= '0;
        end else begin
            for (int c = 0; c < NUM_COLS; c++)
                for (int s = 0; s < SYN_PER_COL; s++)
                    if (cfg_we_i && cfg_col_i == CW'(c) && cfg_syn_i == SW'(s))
                        w_q[c][s] <= cfg_wdata_i;
                    else if (wr_en_i && wr_col_i == CW'(c) && wr_syn_i == SW'(s))
                        w_q[c][s] <= wr_data_i;
        end
    end

endmodule
`default_nettype wire

// File: rtl/synapse_row_tm.sv
`default_nettype none
// ============================================================================
// synapse_row_tm : time-multiplexed synapse row - spike accumulation, decay on
//                  time steps and STDP potentiation, one column per cycle
// Rev 1.0
// ============================================================================
module synapse_row_tm
    import row_pkg::*;
#(
    parameter int NUM_COLS    = 4,
    parameter int SYN_PER_COL = 2,
    parameter int W_WIDTH     = 8,
    parameter int CUR_WIDTH   = 16,
    parameter int TRACE_WIDTH = 8,
    parameter int DECAY_SHIFT = 3,
    localparam int CW = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1,
    localparam int SW = (SYN_PER_COL > 1) ? $clog2(SYN_PER_COL) : 1
) (
    input  logic                          clk,
    input  logic                          reset,
    synapse_row_tm_if.slave               spk,
    input  logic [NUM_COLS-1:0]           post_spike,
    input  logic                          step,
    input  logic                          stdp_en,
    input  logic [W_WIDTH-1:0]            stdp_amplitude,
    input  logic                          cfg_we,
    input  logic [CW-1:0]                 cfg_col,
    input  logic [SW-1:0]                 cfg_syn,
    input  logic [W_WIDTH-1:0]            cfg_wdata,
    output logic [NUM_COLS*CUR_WIDTH-1:0] current_out,
    output logic                          busy
);

    state_e                 state_q;
    logic [CW-1:0]          col_q;
    logic [SW-1:0]          syn_q;
    logic [SW-1:0]          addr_q;
    logic                   addr_ok_q;
    logic                   busy_q;
    logic                   step_pend_q;
    logic [NUM_COLS-1:0]    post_pend_q;
    logic [CUR_WIDTH-1:0]   cur_q   [NUM_COLS];
    logic [TRACE_WIDTH-1:0] trace_q [SYN_PER_COL];

    logic                   w_ready;
    logic                   w_last_col;
    logic                   w_last_syn;
    logic                   w_addr_ok;
    logic                   w_step_clr;
    logic [NUM_COLS-1:0]    w_post_clr;
    logic [SW-1:0]          w_rd_syn;
    logic [W_WIDTH-1:0]     w_rd_data;
    logic [W_WIDTH-1:0]     w_dw;
    logic [W_WIDTH-1:0]     w_w_new;
    logic                   w_fsm_we;
    logic [CUR_WIDTH-1:0]   w_cur_sel;
    logic [CUR_WIDTH-1:0]   w_cur_sum;
    logic [CUR_WIDTH-1:0]   w_cur_dec;
    logic [TRACE_WIDTH-1:0] w_trace_sel;
    logic [TRACE_WIDTH-1:0] w_trace_dec [SYN_PER_COL];

    assign w_ready         = (state_q == ST_IDLE) && !step_pend_q && (post_pend_q == '0);
    assign spk.spike_ready = w_ready;
    assign busy            = busy_q;
    assign w_last_col      = (col_q == CW'(NUM_COLS - 1));
    assign w_last_syn      = (syn_q == SW'(SYN_PER_COL - 1));
    assign w_addr_ok       = (32'(spk.spike_addr) < SYN_PER_COL);
    assign w_step_clr      = (state_q == ST_IDLE) && step_pend_q;
    assign w_rd_syn        = (state_q == ST_ACCUM) ? addr_q : syn_q;

    always_comb begin
        w_cur_sel   = '0;
        w_trace_sel = '0;
        w_post_clr  = '0;
        for (int c = 0; c < NUM_COLS; c++) begin
            if (col_q == CW'(c)) begin
                w_cur_sel     = cur_q[c];
                w_post_clr[c] = (state_q == ST_STDP) && w_last_syn;
            end
        end
        for (int s = 0; s < SYN_PER_COL; s++) begin
            if (syn_q == SW'(s))
                w_trace_sel = trace_q[s];
            w_trace_dec[s] = TRACE_WIDTH'(decay(32'(trace_q[s]), DECAY_SHIFT));
        end
    end

    assign w_cur_sum = CUR_WIDTH'(sat_add(32'(w_cur_sel), 32'(w_rd_data), CUR_WIDTH));
    assign w_cur_dec = CUR_WIDTH'(decay(32'(w_cur_sel), DECAY_SHIFT));
    assign w_dw      = W_WIDTH'(({{W_WIDTH{1'b0}}, w_trace_sel} *
                                 {{TRACE_WIDTH{1'b0}}, stdp_amplitude}) >> TRACE_WIDTH);
    assign w_w_new   = W_WIDTH'(sat_add(32'(w_rd_data), 32'(w_dw), W_WIDTH));
    assign w_fsm_we  = (state_q == ST_STDP) && post_pend_q[col_q];

    row_weight_mem #(
        .NUM_COLS    (NUM_COLS),
        .SYN_PER_COL (SYN_PER_COL),
        .W_WIDTH     (W_WIDTH),
        .CW          (CW),
        .SW          (SW)
    ) u_mem (
        .clk         (clk),
        .reset       (reset),
        .rd_col_i    (col_q),
        .rd_syn_i    (w_rd_syn),
        .rd_data_o   (w_rd_data),
        .wr_en_i     (w_fsm_we),
        .wr_col_i    (col_q),
        .wr_syn_i    (syn_q),
        .wr_data_i   (w_w_new),
        .cfg_we_i    (cfg_we),
        .cfg_col_i   (cfg_col),
        .cfg_syn_i   (cfg_syn),
        .cfg_wdata_i (cfg_wdata)
    );

    // New events win over a same-cycle clear so no pulse is ever lost.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            step_pend_q <= 1'b0;
            post_pend_q <= '0;
        end else begin
            step_pend_q <= step | (step_pend_q & ~w_step_clr);
            post_pend_q <= (post_spike & {NUM_COLS{stdp_en}}) | (post_pend_q & ~w_post_clr);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            col_q     <= '0;
            syn_q     <= '0;
            addr_q    <= '0;
            addr_ok_q <= 1'b0;
            busy_q    <= 1'b0;
            for (int c = 0; c < NUM_COLS; c++)
                cur_q[c] <= '0;
            for (int s = 0; s < SYN_PER_COL; s++)
                trace_q[s] <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    col_q <= '0;
                    syn_q <= '0;
                    if (step_pend_q) begin
                        state_q <= ST_DECAY;
                        busy_q  <= 1'b1;
                    end else if (post_pend_q != '0) begin
                        state_q <= ST_STDP;
                        busy_q  <= 1'b1;
                    end else if (spk.spike_valid) begin
                        state_q   <= ST_ACCUM;
                        busy_q    <= 1'b1;
                        addr_q    <= spk.spike_addr;
                        addr_ok_q <= w_addr_ok;
                        for (int s = 0; s < SYN_PER_COL; s++)
                            if (spk.spike_addr == SW'(s))
                                trace_q[s] <= '1;
                    end
                end
                ST_ACCUM: begin
                    if (addr_ok_q)
                        cur_q[col_q] <= w_cur_sum;
                    col_q <= col_q + CW'(1);
                    if (w_last_col) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                ST_DECAY: begin
                    cur_q[col_q] <= w_cur_dec;
                    if (col_q == '0)
                        for (int s = 0; s < SYN_PER_COL; s++)
                            trace_q[s] <= w_trace_dec[s];
                    col_q <= col_q + CW'(1);
                    if (w_last_col) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                ST_STDP: begin
                    syn_q <= syn_q + SW'(1);
                    if (w_last_syn) begin
                        syn_q <= '0;
                        col_q <= col_q + CW'(1);
                        if (w_last_col) begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    for (genvar c = 0; c < NUM_COLS; c++) begin : g_cur_out
        assign current_out[c*CUR_WIDTH +: CUR_WIDTH] = cur_q[c];
    end

endmodule
`default_nettype wire

// File: tb/tb_synapse_row_tm.sv
`default_nettype none
// ============================================================================
// tb_synapse_row_tm : directed scoreboard bench for synapse_row_tm
// Rev 1.0
// ============================================================================
module tb_synapse_row_tm;

    localparam int NC  = 4;
    localparam int SP  = 2;
    localparam int WW  = 8;
    localparam int CWD = 16;
    localparam int TW  = 8;
    localparam int DS  = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic [NC-1:0]     post_spike;
    logic              step;
    logic              stdp_en;
    logic [WW-1:0]     stdp_amplitude;
    logic              cfg_we;
    logic [1:0]        cfg_col;
    logic [0:0]        cfg_syn;
    logic [WW-1:0]     cfg_wdata;
    logic [NC*CWD-1:0] current_out;
    logic              busy;

    synapse_row_tm_if #(.SYN_PER_COL(SP)) sif ();

    synapse_row_tm #(
        .NUM_COLS(NC), .SYN_PER_COL(SP), .W_WIDTH(WW),
        .CUR_WIDTH(CWD), .TRACE_WIDTH(TW), .DECAY_SHIFT(DS)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .spk            (sif.slave),
        .post_spike     (post_spike),
        .step           (step),
        .stdp_en        (stdp_en),
        .stdp_amplitude (stdp_amplitude),
        .cfg_we         (cfg_we),
        .cfg_col        (cfg_col),
        .cfg_syn        (cfg_syn),
        .cfg_wdata      (cfg_wdata),
        .current_out    (current_out),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_cur [NC];
    int exp_w   [NC][SP];
    int exp_tr  [SP];

    typedef struct { int col; int val; } exp_t;
    exp_t sb[$];

    function automatic int msat(input int a, input int b, input int mx);
        return (a + b > mx) ? mx : a + b;
    endfunction

    function automatic int mdec(input int x);
        return (x < (1 << DS)) ? 0 : x - (x >> DS);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input int expv);
        n_cmp++;
        assert (got === 32'(expv)) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int c = 0; c < NC; c++) begin
            exp_cur[c] = 0;
            for (int s = 0; s < SP; s++) exp_w[c][s] = 0;
        end
        for (int s = 0; s < SP; s++) exp_tr[s] = 0;
        sb.delete();
    endtask

    task automatic wait_ready();
        int k = 0;
        while (sif.spike_ready !== 1'b1 && k < 200) begin
            tick();
            k++;
        end
        if (k >= 200) chk("ready_timeout", 32'(sif.spike_ready), 1);
    endtask

    task automatic cfg_write(input int c, input int s, input int d);
        cfg_we = 1'b1; cfg_col = 2'(c); cfg_syn = 1'(s); cfg_wdata = 8'(d);
        tick();
        cfg_we = 1'b0;
        exp_w[c][s] = d;
    endtask

    task automatic push_accum(input int addr);
        exp_tr[addr] = 255;
        for (int c = 0; c < NC; c++) begin
            exp_cur[c] = msat(exp_cur[c], exp_w[c][addr], 65535);
            sb.push_back('{c, exp_cur[c]});
        end
    endtask

    task automatic pop_check(input string tag);
        exp_t e;
        e = sb.pop_front();
        chk($sformatf("%s c%0d", tag, e.col), 32'(current_out[e.col*CWD +: CWD]), e.val);
    endtask

    // Accept edge is T; column c must update on edge T+1+c.
    task automatic send_spike(input int addr);
        wait_ready();
        sif.spike_valid = 1'b1;
        sif.spike_addr  = 1'(addr);
        push_accum(addr);
        tick();
        sif.spike_valid = 1'b0;
        chk("accum_busy", 32'(busy), 1);
        chk("accum_ready_low", 32'(sif.spike_ready), 0);
        for (int c = 0; c < NC; c++) begin
            tick();
            pop_check("accum");
        end
        chk("accum_ready_back", 32'(sif.spike_ready), 1);
    endtask

    task automatic model_stdp(input logic [NC-1:0] mask, input int amp);
        for (int c = 0; c < NC; c++)
            if (mask[c])
                for (int s = 0; s < SP; s++)
                    exp_w[c][s] = msat(exp_w[c][s], (exp_tr[s] * amp) >> TW, 255);
    endtask

    task automatic post(input logic [NC-1:0] mask, input logic en, input int amp);
        wait_ready();
        post_spike = mask; stdp_en = en; stdp_amplitude = 8'(amp);
        if (en) model_stdp(mask, amp);
        tick();
        post_spike = '0;
        chk("post_ready", 32'(sif.spike_ready), en ? 0 : 1);
    endtask

    // Step at edge T: DECAY entered at T+1, column c decayed at T+2+c.
    task automatic do_step();
        wait_ready();
        step = 1'b1;
        for (int c = 0; c < NC; c++) begin
            exp_cur[c] = mdec(exp_cur[c]);
            sb.push_back('{c, exp_cur[c]});
        end
        for (int s = 0; s < SP; s++) exp_tr[s] = mdec(exp_tr[s]);
        tick();
        step = 1'b0;
        chk("step_ready_low", 32'(sif.spike_ready), 0);
        tick();
        chk("decay_busy", 32'(busy), 1);
        for (int c = 0; c < NC; c++) begin
            tick();
            pop_check("decay");
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; post_spike = '0; step = 1'b0; stdp_en = 1'b0;
        stdp_amplitude = '0; cfg_we = 1'b0; cfg_col = '0; cfg_syn = '0; cfg_wdata = '0;
        sif.spike_valid = 1'b0; sif.spike_addr = '0;
        model_clear();
        tick(); tick();
        chk("rst_current", 32'(current_out == '0), 1);
        chk("rst_ready", 32'(sif.spike_ready), 1);
        chk("rst_busy", 32'(busy), 0);
        reset = 1'b0;
        tick();

        // Accumulation: 10/20/30/40 then 20/40/60/80
        for (int c = 0; c < NC; c++) cfg_write(c, 0, 10 * (c + 1));
        send_spike(0);
        send_spike(0);

        // Async reset in the middle of ACCUM
        wait_ready();
        sif.spike_valid = 1'b1; sif.spike_addr = 1'b0;
        tick();
        sif.spike_valid = 1'b0;
        tick(); tick();
        reset = 1'b1;
        #1;
        chk("midrst_current", 32'(current_out == '0), 1);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_ready", 32'(sif.spike_ready), 1);
        model_clear();
        tick();
        reset = 1'b0;
        send_spike(0);
        send_spike(1);

        // Decay of currents and traces
        cfg_write(0, 0, 40); cfg_write(1, 0, 5); cfg_write(2, 0, 8); cfg_write(3, 0, 0);
        send_spike(0);
        do_step();
        post(4'b0100, 1'b1, 16);
        send_spike(0);

        // STDP potentiation, untouched slots, stdp_en gating
        cfg_write(1, 0, 100); cfg_write(1, 1, 50);
        post(4'b0010, 1'b1, 16);
        send_spike(1);
        send_spike(0);
        post(4'b0010, 1'b0, 16);
        send_spike(0);

        // STDP weight saturation 250 + 15
        cfg_write(0, 0, 250);
        post(4'b0001, 1'b1, 16);
        send_spike(0);

        // Config write collides with the STDP write of w[1][0]
        send_spike(1);
        wait_ready();
        post_spike = 4'b0010; stdp_en = 1'b1; stdp_amplitude = 8'd16;
        model_stdp(4'b0010, 16);
        tick();
        post_spike = '0;
        tick(); tick(); tick();
        cfg_we = 1'b1; cfg_col = 2'd1; cfg_syn = 1'b0; cfg_wdata = 8'd77;
        tick();
        cfg_we = 1'b0;
        exp_w[1][0] = 77;
        send_spike(0);
        send_spike(1);

        // Step and spike request in the same cycle while STDP is pending
        wait_ready();
        post_spike = 4'b1000; stdp_en = 1'b1; stdp_amplitude = 8'd16;
        model_stdp(4'b1000, 16);
        tick();
        post_spike = '0;
        step = 1'b1; sif.spike_valid = 1'b1; sif.spike_addr = 1'b0;
        tick();
        step = 1'b0;
        for (int c = 0; c < NC; c++) exp_cur[c] = mdec(exp_cur[c]);
        for (int s = 0; s < SP; s++) exp_tr[s] = mdec(exp_tr[s]);
        wait_ready();
        for (int c = 0; c < NC; c++)
            chk($sformatf("prio_decayed c%0d", c), 32'(current_out[c*CWD +: CWD]), exp_cur[c]);
        push_accum(0);
        tick();
        sif.spike_valid = 1'b0;
        for (int c = 0; c < NC; c++) begin
            tick();
            pop_check("prio_accum");
        end

        // Current saturation
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_clear();
        for (int c = 0; c < NC; c++)
            for (int s = 0; s < SP; s++) cfg_write(c, s, 255);
        for (int i = 0; i < 259; i++) send_spike(1);
        for (int c = 0; c < NC; c++)
            chk($sformatf("sat_final c%0d", c), 32'(current_out[c*CWD +: CWD]), 65535);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/synapse_row_tm.md
# synapse_row_tm

Time-multiplexed, parametrised synapse row: a successor to the fixed two-synapses-per-dendrite row. It holds a `NUM_COLS` × `SYN_PER_COL` weight array and a pre-synaptic STDP trace per synapse slot. It accumulates incoming row spikes into per-column dendrite currents one column per cycle, and applies current/trace decay on a time-step strobe and STDP potentiation on post-synaptic spikes. It sits between the row spike input and the column neurons and drives their dendrite current inputs.

## Interface
- `NUM_COLS`, 4: number of columns (dendrite/neuron pairs).
- `SYN_PER_COL`, 2: synapses per column; the spike address selects the slot.
- `W_WIDTH`, 8: unsigned weight width.
- `CUR_WIDTH`, 16: unsigned dendrite current width.
- `TRACE_WIDTH`, 8: unsigned pre-trace width.
- `DECAY_SHIFT`, 3: decay factor of 2^-DECAY_SHIFT per step.

Ports:
- `clk`  in  1  single clock; all state on its rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `spike_valid`  in  1  row input spike request.
- `spike_addr`  in  $clog2(SYN_PER_COL)  synapse slot hit in every column.
- `spike_ready`  out  1  spike accepted on `spike_valid & spike_ready`.
- `post_spike`  in  NUM_COLS  neuron output spikes, one-cycle pulses.
- `step`  in  1  time-step strobe, one-cycle pulse.
- `stdp_en`  in  1  enables latching of `post_spike`.
- `stdp_amplitude`  in  W_WIDTH  STDP gain.
- `cfg_we`, `cfg_col`, `cfg_syn`, `cfg_wdata`  in  1 / $clog2(NUM_COLS) / $clog2(SYN_PER_COL) / W_WIDTH  direct weight write.
- `current_out`  out  NUM_COLS*CUR_WIDTH  dendrite currents; column c is at bits [c*CUR_WIDTH +: CUR_WIDTH].
- `busy`  out  1  FSM not in IDLE.

## Operation
- **States.** IDLE, ACCUM, DECAY, STDP. A column counter `col` and a slot counter `syn` are used by ACCUM/DECAY/STDP.
- **Event latching.**
  - `step` sets `step_pend`.
  - `post_spike[c] & stdp_en` sets `post_pend[c]`. When `stdp_en` is 0, `post_spike` is ignored.
  - A set and a clear of the same bit in one cycle: set wins.
- **IDLE priority.** First `step_pend` → DECAY. Otherwise `|post_pend` → STDP. Otherwise a spike handshake → ACCUM.
- **spike_ready.** Equals 1 only when in IDLE with `step_pend` = 0 and `post_pend` = 0.
- **Spike accept.** On the accepting edge: latch `spike_addr` and set `trace[spike_addr]` to 2^TRACE_WIDTH−1.
- **ACCUM.** NUM_COLS cycles, `col` = 0..NUM_COLS−1. Each cycle: `cur[col]` ← `min(cur[col] + w[col][addr], 2^CUR_WIDTH−1)`.
- **DECAY.** NUM_COLS cycles.
  - Each cycle: `cur[col]` ← 0 if `cur[col]` < 2^DECAY_SHIFT; else `cur[col] − (cur[col] >> DECAY_SHIFT)`.
  - First cycle only: every trace is decayed by the same rule.
  - `step_pend` clears at entry.
- **STDP.** NUM_COLS*SYN_PER_COL cycles, `syn` inner, `col` outer.
  - If `post_pend[col]`: `w[col][syn]` ← `min(w + ((trace[syn]*stdp_amplitude) >> TRACE_WIDTH), 2^W_WIDTH−1)`.
  - `post_pend[col]` clears on that column's last slot.
  - A post spike for a column already passed stays pending for the next pass.
- **Config write.** `cfg_we` is honoured in any state. If it collides with an STDP write to the same weight, the config write wins.
- **Out-of-range addresses.** Config writes are dropped. Spikes are accepted with no current effect; the trace is not set.

## Timing
- **Reset values.** `current_out` 0, `spike_ready` 1, `busy` 0. All weights, traces, pending bits and counters 0; FSM in IDLE.
- **Async reset** mid-operation aborts the operation immediately. No partial update survives.
- **Spike latency.** Spike accepted at edge T: `cur[c]` is updated at edge T+1+c. `busy` is high for cycles T+1..T+NUM_COLS. `spike_ready` returns at T+NUM_COLS.
- **Step latency.** `step` at edge T with the FSM in IDLE: DECAY entered at edge T+1 and runs NUM_COLS cycles. Column c is decayed at edge T+2+c.
- **Step during another state.** `step` is queued and serviced when the current operation returns to IDLE.
- **Output.** `current_out` is registered; no combinational path from any input to any output.
- **Config write** takes effect at the next edge.

## Structure
- **Shared package `row_pkg`:**
  - FSM state enum.
  - `sat_add` function (unsigned saturating add, width-generic via parameterised class or per-width wrapper).
  - `decay` function.
- **Sub-module `row_weight_mem`:**
  - NUM_COLS × SYN_PER_COL register array.
  - One read port (FSM), one write port (FSM).
  - Config write port with priority over the FSM write.
- **Top-level contents:** FSM, counters, traces, currents, pending registers.

## Test plan
Default parameters unless noted.
1. **Reset:** assert `reset` mid-ACCUM → `current_out` 0, `busy` 0, `spike_ready` 1 immediately; all weights read 0 afterwards.
2. **Accumulate:** write `w[c][0]` = 10*(c+1), spike addr 0 at edge T → currents 10/20/30/40 at edges T+1..T+4; `spike_ready` low for 4 cycles; a second spike → 20/40/60/80.
3. **Saturation:** all weights 255, 258 spikes on addr 1 → every current 65535; further spikes hold 65535. STDP on weight 250 with dw=15 → 255.
4. **Decay:** currents 40/5/8/0, `step` → 35/0/7/0. `trace[0]` 255 → 224 after one step.
5. **STDP:**
   - Spike addr 0 (`trace[0]` = 255), `stdp_amplitude` 16, `post_spike[1]` → `w[1][0]` += 15.
   - `w[1][1]` unchanged; other columns unchanged.
   - With `stdp_en` = 0 the same stimulus changes nothing.
6. **Priority and collisions:**
   - `step` and `spike_valid` in the same cycle → spike not accepted until DECAY is done.
   - `cfg_we` to `w[1][0]` during the STDP update of `w[1][0]` → config value retained.
